// File: rtl/pll_pkg.sv
// Shared definitions for the PLL control blocks: counter width and the
// period meter state encoding.
package pll_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        PM_IDLE    = 2'd0,
        PM_ARM     = 2'd1,
        PM_MEASURE = 2'd2
    } pm_state_e;

endpackage

// File: rtl/period_meter_if.sv
// Control and result bundle of the period meter. The slave side is the meter;
// the master side is whoever drives the measured clock and reads results.
interface period_meter_if;
    import pll_pkg::*;

    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output en, sig_in,
        input  period, high_time, meas_valid, locked, timeout
    );

    modport slave (
        input  en, sig_in,
        output period, high_time, meas_valid, locked, timeout
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, plus one delay flop that
// turns the synchronized level into single-cycle rise/fall pulses.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~dly_q;
    assign fall = ~q & dly_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow clock in clk_in cycles, with
// frequency-lock and loss-of-input detection.
//
// state      | meaning
// PM_IDLE    | disabled; counters cleared, lock/timeout dropped
// PM_ARM     | waiting for the first rising edge to start a period
// PM_MEASURE | counting between rising edges; strobes a result on each rise
module period_meter
    import pll_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = 32'd1048576
) (
    input logic          clk_in,
    input logic          rst_n,
    period_meter_if.slave pm
);

    logic sig_s, rise, fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .d      (pm.sig_in),
        .q      (sig_s),
        .rise   (rise),
        .fall   (fall)
    );

    pm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] prev_period_q, prev_period_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_lat_d      = hi_lat_q;
        prev_period_d = prev_period_q;
        first_d       = first_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        meas_valid_d  = 1'b0;
        locked_d      = locked_q;
        timeout_d     = timeout_q;

        if (!pm.en) begin
            state_d   = PM_IDLE;
            cnt_d     = '0;
            first_d   = 1'b1;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                PM_IDLE: begin
                    cnt_d     = '0;
                    first_d   = 1'b1;
                    locked_d  = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = PM_ARM;
                end
                PM_ARM, PM_MEASURE: begin
                    // A rise on the timeout cycle still counts as a live input
                    if (rise) begin
                        cnt_d     = CNT_W'(1);
                        timeout_d = 1'b0;
                        state_d   = PM_MEASURE;
                        if (state_q == PM_MEASURE) begin
                            period_d      = cnt_q;
                            high_time_d   = hi_lat_q;
                            meas_valid_d  = 1'b1;
                            locked_d      = !first_q && (cnt_q == prev_period_q);
                            prev_period_d = cnt_q;
                            first_d       = 1'b0;
                        end
                    end else if (cnt_q == TIMEOUT) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        first_d   = 1'b1;
                        cnt_d     = '0;
                        state_d   = PM_ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (fall && state_q == PM_MEASURE) hi_lat_d = cnt_q;
                    end
                end
                default: state_d = PM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PM_IDLE;
            cnt_q         <= '0;
            hi_lat_q      <= '0;
            prev_period_q <= '0;
            first_q       <= 1'b1;
            period_q      <= '0;
            high_time_q   <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_lat_q      <= hi_lat_d;
            prev_period_q <= prev_period_d;
            first_q       <= first_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            meas_valid_q  <= meas_valid_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
        end
    end

    assign pm.period     = period_q;
    assign pm.high_time  = high_time_q;
    assign pm.meas_valid = meas_valid_q;
    assign pm.locked     = locked_q;
    assign pm.timeout    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: waveform table with expected strobes, then
// timeout, enable-drop and async-reset sequences.
module tb_period_meter;
    import pll_pkg::*;

    localparam logic [CNT_W-1:0] TMO = 32'd64;

    typedef struct {
        int          h;
        int          l;
        logic [31:0] per;
        logic [31:0] hi;
        logic        lk;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] per;
        logic [31:0] hi;
        logic        lk;
        logic        to;
    } strobe_t;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    period_meter_if pm_if ();

    period_meter #(.SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pm     (pm_if)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    strobe_t sq[$];
    always @(negedge clk_in)
        if (pm_if.meas_valid === 1'b1)
            sq.push_back('{cyc, pm_if.period, pm_if.high_time, pm_if.locked, pm_if.timeout});

    int n_chk  = 0;
    int n_pass = 0;
    vec_t vecs[10];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input int h, input int l);
        pm_if.sig_in = 1'b1;
        repeat (h) tick();
        pm_if.sig_in = 1'b0;
        repeat (l) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int b;
        b = budget;
        while (sq.size() < n && b > 0) begin
            @(negedge clk_in);
            b--;
        end
        if (sq.size() < n) begin
            n_chk++;
            $display("FAIL strobe_wait: got %0d strobes expected %0d", sq.size(), n);
        end
    endtask

    task automatic check_strobe(input int idx, input logic [31:0] per, input logic [31:0] hi,
                                input logic lk);
        if (idx >= sq.size()) begin
            n_chk++;
            $display("FAIL strobe%0d_missing: got %0d strobes expected more than %0d",
                     idx, sq.size(), idx);
        end else begin
            chk($sformatf("strobe%0d_period", idx), sq[idx].per, per);
            chk($sformatf("strobe%0d_high_time", idx), sq[idx].hi, hi);
            chk($sformatf("strobe%0d_locked", idx), 32'(sq[idx].lk), 32'(lk));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_period"},     pm_if.period, 32'd0);
        chk({tag, "_high_time"},  pm_if.high_time, 32'd0);
        chk({tag, "_meas_valid"}, 32'(pm_if.meas_valid), 32'd0);
        chk({tag, "_locked"},     32'(pm_if.locked), 32'd0);
        chk({tag, "_timeout"},    32'(pm_if.timeout), 32'd0);
    endtask

    initial begin
        int s_cyc;
        bit seen;

        for (int i = 0; i < 4; i++)  vecs[i] = '{3, 5, 32'd8, 32'd3, (i != 0)};
        for (int i = 4; i < 7; i++)  vecs[i] = '{5, 5, 32'd10, 32'd5, (i != 4)};
        for (int i = 7; i < 10; i++) vecs[i] = '{1, 1, 32'd2, 32'd1, (i != 7)};

        pm_if.en     = 1'b0;
        pm_if.sig_in = 1'b0;
        #23;
        check_outputs_zero("reset");
        @(posedge clk_in);
        #3 rst_n = 1'b1;
        tick();
        pm_if.en = 1'b1;
        tick();
        tick();

        // Contiguous waveform; strobe i reports driven period i on the next rise
        for (int i = 0; i < 10; i++) drive(vecs[i].h, vecs[i].l);
        pm_if.sig_in = 1'b1;
        tick();
        pm_if.sig_in = 1'b0;
        wait_strobes(10, 20);
        for (int i = 0; i < 10; i++) begin
            check_strobe(i, vecs[i].per, vecs[i].hi, vecs[i].lk);
            if (i > 0 && sq.size() > i)
                chk($sformatf("strobe%0d_spacing", i), 32'(sq[i].cyc - sq[i-1].cyc), vecs[i].per);
        end

        // Input stalls low after the last rise
        s_cyc = (sq.size() >= 10) ? sq[9].cyc : cyc;
        seen  = 1'b0;
        repeat (100) begin
            @(negedge clk_in);
            if (!seen && cyc == s_cyc + 63) chk("timeout_early", 32'(pm_if.timeout), 32'd0);
            if (!seen && cyc == s_cyc + 64) begin
                chk("timeout_set", 32'(pm_if.timeout), 32'd1);
                chk("timeout_locked", 32'(pm_if.locked), 32'd0);
                seen = 1'b1;
            end
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL timeout_window: got cycle %0d expected %0d", cyc, s_cyc + 64);
        end

        // Resume: first rise clears timeout without a strobe
        pm_if.sig_in = 1'b1;
        repeat (4) tick();
        chk("timeout_clear", 32'(pm_if.timeout), 32'd0);
        chk("resume_no_strobe", 32'(sq.size()), 32'd10);
        pm_if.sig_in = 1'b0;
        repeat (4) tick();
        drive(4, 4);
        drive(4, 4);
        pm_if.sig_in = 1'b1;
        repeat (4) tick();
        pm_if.sig_in = 1'b0;
        repeat (2) tick();
        wait_strobes(13, 20);
        check_strobe(10, 32'd8, 32'd4, 1'b0);
        check_strobe(11, 32'd8, 32'd4, 1'b1);
        check_strobe(12, 32'd8, 32'd4, 1'b1);
        if (sq.size() > 10) chk("resume_strobe_timeout", 32'(sq[10].to), 32'd0);

        // Enable dropped mid-period
        pm_if.en = 1'b0;
        tick();
        chk("en_drop_locked", 32'(pm_if.locked), 32'd0);
        chk("en_drop_period", pm_if.period, 32'd8);
        chk("en_drop_high", pm_if.high_time, 32'd4);
        drive(4, 4);
        drive(4, 4);
        chk("en_low_no_strobe", 32'(sq.size()), 32'd13);
        chk("en_low_period_hold", pm_if.period, 32'd8);

        pm_if.en = 1'b1;
        drive(2, 4);
        chk("reenable_one_rise", 32'(sq.size()), 32'd13);
        drive(2, 4);
        drive(2, 4);
        pm_if.sig_in = 1'b1;
        repeat (3) tick();
        wait_strobes(16, 20);
        check_strobe(13, 32'd6, 32'd2, 1'b0);
        check_strobe(14, 32'd6, 32'd2, 1'b1);
        check_strobe(15, 32'd6, 32'd2, 1'b1);

        // Asynchronous reset between clock edges, mid-measurement
        pm_if.sig_in = 1'b0;
        repeat (2) tick();
        #3 rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        drive(3, 4);
        chk("post_rst_one_rise", 32'(sq.size()), 32'd16);
        drive(3, 4);
        pm_if.sig_in = 1'b1;
        repeat (3) tick();
        pm_if.sig_in = 1'b0;
        wait_strobes(18, 20);
        check_strobe(16, 32'd7, 32'd3, 1'b0);
        check_strobe(17, 32'd7, 32'd3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, possibly asynchronous clock (divided-clock or feedback clock) in units of `clk_in` cycles, and reports each completed measurement with a one-cycle valid strobe. It is the receiving end of the divided-clock path: it recovers the division ratio and duty from the waveform. It also flags frequency lock (two consecutive equal periods) and loss of input (timeout). It sits between the divider/feedback path and the PLL control or debug logic.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop count on `sig_in`; legal range ≥2.
- `TIMEOUT`, 1048576: cycles without a detected rising edge before `timeout` asserts; legal range 2 .. 2^32−1.

- `clk_in`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  measurement enable; low forces IDLE.
- `sig_in`  in  1  measured clock; asynchronous to `clk_in`.
- `period`  out  32  last measured period in `clk_in` cycles.
- `high_time`  out  32  last measured high time in `clk_in` cycles.
- `meas_valid`  out  1  one-cycle strobe; `period`/`high_time` updated this cycle.
- `locked`  out  1  last two periods equal.
- `timeout`  out  1  no rising edge for `TIMEOUT` cycles; sticky until the next rise.

## Operation
- `sig_in` passes through `SYNC_STAGES` flops to give `sig_s`; one more flop gives `sig_d`. `rise` = `sig_s & ~sig_d`; `fall` = `~sig_s & sig_d`.
- Internal 32-bit `cnt`, 32-bit `hi_lat`, 32-bit `prev_period`, and a `first` flag.
- States:
  - **IDLE**
    - `cnt`=0, `first`=1, `locked`=0, `timeout`=0.
    - If `en`=1, go to ARM next cycle.
  - **ARM**
    - `cnt` increments each cycle.
    - On `rise`: `cnt`←1, `timeout`←0, go to MEASURE.
  - **MEASURE**
    - Default: `cnt`←`cnt`+1.
    - On `fall`: `hi_lat`←`cnt`.
    - On `rise`:
      - Updates: `period`←`cnt`, `high_time`←`hi_lat`, `meas_valid`←1, `cnt`←1, `timeout`←0.
      - Lock: `locked`←(!`first` && `cnt`==`prev_period`); then `prev_period`←`cnt`, `first`←0.
- Timeout:
  - Applies in ARM or MEASURE when `cnt`==`TIMEOUT` and there is no `rise`.
  - Effect: `timeout`←1, `locked`←0, `first`←1, `cnt`←0, state←ARM.
- Measurements are exact for a `sig_s` waveform with a period of P cycles and a high time of H cycles: `period`=P, `high_time`=H.
  - Minimum legal input is P=2, H=1.
  - Input pulses shorter than one `clk_in` cycle alias; the result is undefined and not checked.
- `en` low in any state: next state IDLE. `period`/`high_time` hold their last values, and no `meas_valid` is issued.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; all outputs 0.
  - `cnt`, `hi_lat`, `prev_period` and synchronizer flops are 0; `first`=1.
- `sig_in` edge to `rise`/`fall` detection: `SYNC_STAGES`+1 cycles.
- `meas_valid`:
  - Registered; high in the cycle after the detecting cycle, and exactly one cycle wide.
  - `period`, `high_time` and `locked` change in that same cycle.
- First `meas_valid` after ARM follows the second detected rising edge. `locked` can first be 1 at the second `meas_valid`.
- Simultaneous events:
  - `rise` with `cnt`==`TIMEOUT`: `rise` wins; no timeout.
  - `rise` with `en` falling: `en` wins; IDLE, no `meas_valid`.
- `rst_n` asserted mid-measurement: abort immediately with no strobe. After release, start in IDLE.

## Structure
- Shared package `pll_pkg`: `CNT_W`=32 and the state enum (`PM_IDLE`, `PM_ARM`, `PM_MEASURE`).
- Sub-module `sync_edge`:
  - Parameters: `SYNC_STAGES`.
  - Inputs: `clk_in`, `rst_n`, `d`.
  - Outputs: `q`, `rise`, `fall`.
- Reused by other clock-domain inputs in the design.

## Test plan
- Reset, `en`=1, `sig_in` square 3 high/5 low (synchronous to `clk_in`) -> every `meas_valid` reports `period`=8, `high_time`=3; `locked`=0 at the first strobe and 1 from the second strobe on; strobes 8 cycles apart.
- Period switches 8->10 (5/5) -> the first 10-cycle strobe reports 10/5 with `locked`=0; the next strobe gives `locked`=1.
- `TIMEOUT`=64, `sig_in` held low after a rise at detection cycle t0 -> `timeout`=1 and `locked`=0 at t0+65. Resume toggling -> `timeout` clears on the first rise; a valid measurement follows on the next rise.
- `en` dropped mid-period -> IDLE next cycle, no `meas_valid`, `period`/`high_time` unchanged, `locked`=0. Re-enable -> two rises are needed before the next strobe.
- `rst_n` pulsed low asynchronously (between clock edges) mid-measurement -> all outputs 0 immediately; no strobe after release until two new rises.
- Minimum input 1 high/1 low -> `period`=2, `high_time`=1 on each strobe; `locked`=1 from the second strobe.
